branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch unit for the MIPS pipeline: resolves conditional branches in EX (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ) and predicts them in IF from a table of saturating counters, optionally gshare-indexed by a global history register. It replaces the purely combinational branch decision. It also flags mispredictions and keeps resolution/misprediction statistics.

## Interface
- ENTRIES, 64: counter-table depth; power of two, 4..1024; IDX = log2(ENTRIES)
- CTR_BITS, 2: counter width, 1..4
- GHR_BITS, 0: global history length, 0..IDX; 0 = bimodal, >0 = gshare
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- lookup_pc  in  32  IF-stage PC
- predict_taken  out  1  prediction for lookup_pc
- predict_index  out  IDX  table index used; carried down the pipeline
- resolve_valid  in  1  EX stage holds a valid instruction
- resolve_index  in  IDX  predict_index carried from IF
- resolve_pred_taken  in  1  predict_taken carried from IF
- opcode  in  6  instruction[31:26]
- rt  in  5  instruction[20:16]
- alu_zero  in  1  rs==rt (BEQ/BNE) or rs==0 (others)
- alu_neg  in  1  rs is negative (rs[31])
- is_branch  out  1  EX instruction is a conditional branch
- take_branch  out  1  actual outcome
- mispredict  out  1  is_branch & resolve_valid & (take_branch != resolve_pred_taken)
- branch_count  out  32  resolved branches since reset
- mispredict_count  out  32  mispredictions since reset

## Operation
- Resolution (combinational): 0x04 BEQ: alu_zero; 0x05 BNE: !alu_zero; 0x06 BLEZ: alu_zero|alu_neg; 0x07 BGTZ: !alu_zero&!alu_neg; 0x01 REGIMM: rt==0 BLTZ: alu_neg, rt==1 BGEZ: !alu_neg, other rt: not a branch. All other opcodes: is_branch=0, take_branch=0.
- Lookup: base = lookup_pc[IDX+1:2]; predict_index = base XOR zero-extended GHR (GHR_BITS=0: base). predict_taken = MSB of counter[predict_index].
- Update (when resolve_valid & is_branch): counter[resolve_index] +1 if taken, −1 if not, saturating at 0 and 2^CTR_BITS−1; GHR <= {GHR[GHR_BITS-2:0], take_branch}; branch_count +1; mispredict_count +1 if mispredict. Statistics saturate at 0xFFFFFFFF.
- No update when resolve_valid=0 or is_branch=0; mispredict forced 0 then.

## Timing
- Lookup and resolution outputs combinational, zero latency.
- Counter, GHR and statistics updates take effect at the rising clk edge after resolve; visible to lookup next cycle.
- Same-index lookup and update in one cycle: lookup returns the pre-update value (no bypass).
- Reset (any cycle, including mid-stream): every counter <= 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for 2 bits, 0 for 1 bit), GHR <= 0, both statistics <= 0. During rst, updates are suppressed; combinational outputs still track inputs but reflect reset state next cycle.
- Prediction outputs after reset: predict_taken=0 for all PCs.

## Structure
- Shared package branch_pkg: opcode constants OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ; REGIMM rt codes RT_BLTZ, RT_BGEZ.
- Sub-module branch_cond: combinational resolution (opcode, rt, alu_zero, alu_neg -> is_branch, take_branch); reused by the bench's reference model.
- Top holds counter array, GHR, statistics, saturating arithmetic.

## Test plan
- Resolution sweep: all 64 opcodes × rt∈{0,1,2} × (alu_zero,alu_neg)∈{00,01,10,11} -> e.g. BLEZ with 01 taken, BGTZ with 00 taken, REGIMM rt=2 is_branch=0, opcode 0x08 is_branch=0.
- Training (CTR_BITS=2, GHR_BITS=0): resolve BEQ taken at index 5 twice -> predict_taken for PC 0x14 goes 0,1 (01->10->11); then one not-taken -> still 1; second -> 0.
- Saturation: 5 not-taken at index 3 -> counter stays 0, no wrap; 5 taken -> stays 3.
- Mispredict/stats: 10 branches, resolve_pred_taken mismatches on 3 -> branch_count=10, mispredict_count=3; non-branch ADD with resolve_valid=1 -> counts unchanged, mispredict=0.
- Gshare (GHR_BITS=4): resolve taken,taken,not,taken -> GHR=4'b1101; lookup_pc 0x40 -> predict_index = 0x10^0xD = 0x1D.
- Reset mid-run: train index 7 to 11, assert rst one cycle alongside resolve_valid BEQ -> counter 01, counts 0, GHR 0, predict_taken 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Branch unit shared definitions: MIPS branch opcodes, REGIMM rt codes
// and a saturating 32-bit increment used by the statistics counters.
package branch_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Predictor bundle: IF lookup (pc -> prediction/index), EX resolve
// (carried index/prediction + decode fields -> outcome) and statistics.
interface branch_predictor_if #(
  parameter int ENTRIES = 64
);
  localparam int IDX = $clog2(ENTRIES);

  logic [31:0]    lookup_pc;
  logic           predict_taken;
  logic [IDX-1:0] predict_index;

  logic           resolve_valid;
  logic [IDX-1:0] resolve_index;
  logic           resolve_pred_taken;
  logic [5:0]     opcode;
  logic [4:0]     rt;
  logic           alu_zero;
  logic           alu_neg;

  logic           is_branch;
  logic           take_branch;
  logic           mispredict;
  logic [31:0]    branch_count;
  logic [31:0]    mispredict_count;

  modport master (
    output lookup_pc, resolve_valid, resolve_index,
    output resolve_pred_taken, opcode, rt, alu_zero, alu_neg,
    input  predict_taken, predict_index, is_branch,
    input  take_branch, mispredict, branch_count,
    input  mispredict_count
  );

  modport slave (
    input  lookup_pc, resolve_valid, resolve_index,
    input  resolve_pred_taken, opcode, rt, alu_zero, alu_neg,
    output predict_taken, predict_index, is_branch,
    output take_branch, mispredict, branch_count,
    output mispredict_count
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch resolution for BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ.
// In: opcode_i, rt_i, alu_zero_i, alu_neg_i. Out: is_branch_o, take_branch_o.
module branch_cond
  import branch_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rt_i,
  input  logic       alu_zero_i,
  input  logic       alu_neg_i,
  output logic       is_branch_o,
  output logic       take_branch_o
);

  logic regimm;
  assign regimm = (opcode_i == OP_REGIMM);

  always_comb begin
    is_branch_o   = 1'b0;
    take_branch_o = 1'b0;
    unique case (1'b1)
      opcode_i == OP_BEQ: begin
        is_branch_o   = 1'b1;
        take_branch_o = alu_zero_i;
      end
      opcode_i == OP_BNE: begin
        is_branch_o   = 1'b1;
        take_branch_o = !alu_zero_i;
      end
      opcode_i == OP_BLEZ: begin
        is_branch_o   = 1'b1;
        take_branch_o = alu_zero_i | alu_neg_i;
      end
      opcode_i == OP_BGTZ: begin
        is_branch_o   = 1'b1;
        take_branch_o = !alu_zero_i & !alu_neg_i;
      end
      regimm && (rt_i == RT_BLTZ): begin
        is_branch_o   = 1'b1;
        take_branch_o = alu_neg_i;
      end
      regimm && (rt_i == RT_BGEZ): begin
        is_branch_o   = 1'b1;
        take_branch_o = !alu_neg_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Counter-table branch predictor (bimodal or gshare) with EX resolution,
// mispredict flag and saturating statistics. Ports: clk, rst, bp (slave).
module branch_predictor
  import branch_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0
) (
  input logic             clk,
  input logic             rst,
  branch_predictor_if.slave bp
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;

  localparam logic [CTR_BITS-1:0] CMAX  = '1;
  // Weakly not-taken: all ones below the MSB.
  localparam logic [CTR_BITS-1:0] CINIT = CMAX >> 1;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [GW-1:0]       ghr_q, ghr_d;
  logic [31:0]         bcnt_q, bcnt_d;
  logic [31:0]         mcnt_q, mcnt_d;
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;

  logic           is_br, take;
  logic           upd;
  logic [IDX-1:0] ghr_ext;
  logic [IDX-1:0] base;
  logic [IDX-1:0] pidx;

  branch_cond u_cond (
    .opcode_i      (bp.opcode),
    .rt_i          (bp.rt),
    .alu_zero_i    (bp.alu_zero),
    .alu_neg_i     (bp.alu_neg),
    .is_branch_o   (is_br),
    .take_branch_o (take)
  );

  assign bp.is_branch   = is_br;
  assign bp.take_branch = take;
  assign bp.mispredict  = is_br & bp.resolve_valid &
                          (take != bp.resolve_pred_taken);

  assign upd = bp.resolve_valid & is_br;

  // Lookup: pc word index folded with zero-extended history.
  always_comb begin
    ghr_ext = '0;
    if (GHR_BITS > 0) ghr_ext[GW-1:0] = ghr_q;
  end

  assign base = bp.lookup_pc[IDX+1:2];
  assign pidx = base ^ ghr_ext;

  assign bp.predict_index = pidx;
  assign bp.predict_taken = ctr_q[pidx][CTR_BITS-1];

  // Saturating counter step for the resolved entry.
  always_comb begin
    ctr_cur = ctr_q[bp.resolve_index];
    ctr_d   = ctr_cur;
    if (take) begin
      if (ctr_cur != CMAX) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
    end
  end

  generate
    if (GHR_BITS == 0) begin : g_no_ghr
      assign ghr_d = '0;
    end else if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_d = take;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GW-2:0], take};
    end
  endgenerate

  always_comb begin
    bcnt_d = sat_inc32(bcnt_q);
    mcnt_d = bp.mispredict ? sat_inc32(mcnt_q) : mcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CINIT;
      ghr_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (upd) begin
      ctr_q[bp.resolve_index] <= ctr_d;
      ghr_q  <= ghr_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bp.branch_count     = bcnt_q;
  assign bp.mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench: bimodal and gshare instances driven in lockstep, checked
// against a table/arithmetic reference model of predictor behaviour.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.ENTRIES(64)) bi ();
  branch_predictor_if #(.ENTRIES(64)) gi ();

  branch_predictor #(
    .ENTRIES(64), .CTR_BITS(2), .GHR_BITS(0)
  ) u_bim (
    .clk (clk),
    .rst (rst),
    .bp  (bi)
  );

  branch_predictor #(
    .ENTRIES(64), .CTR_BITS(2), .GHR_BITS(4)
  ) u_gsh (
    .clk (clk),
    .rst (rst),
    .bp  (gi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cnt [64];
  int ghr, bc, mc;

  logic [31:0] s_pc;
  bit          s_v, s_pr, s_z, s_n, s_rst;
  int          s_idx, s_op, s_rt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_res(input int op, input int rtv,
                                  input bit z, input bit n,
                                  output bit br, output bit tk);
    br = 1; tk = 0;
    case (op)
      4: tk = z;
      5: tk = !z;
      6: tk = z || n;
      7: tk = !z && !n;
      1: begin
        if (rtv == 0) tk = n;
        else if (rtv == 1) tk = !n;
        else br = 0;
      end
      default: br = 0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] pc, input bit v, input int idx,
                       input bit pr, input int op, input int rtv,
                       input bit z, input bit n, input bit r);
    s_pc = pc; s_v = v; s_idx = idx; s_pr = pr;
    s_op = op; s_rt = rtv; s_z = z; s_n = n; s_rst = r;
    rst = r;
    bi.lookup_pc = pc;          gi.lookup_pc = pc;
    bi.resolve_valid = v;       gi.resolve_valid = v;
    bi.resolve_index = 6'(idx); gi.resolve_index = 6'(idx);
    bi.resolve_pred_taken = pr; gi.resolve_pred_taken = pr;
    bi.opcode = 6'(op);         gi.opcode = 6'(op);
    bi.rt = 5'(rtv);            gi.rt = 5'(rtv);
    bi.alu_zero = z;            gi.alu_zero = z;
    bi.alu_neg = n;             gi.alu_neg = n;
  endtask

  task automatic check_now();
    bit br, tk, mp;
    int base, gidx;
    ref_res(s_op, s_rt, s_z, s_n, br, tk);
    mp = br && s_v && (tk != s_pr);
    base = (s_pc >> 2) % 64;
    gidx = base ^ ghr;
    chk("is_branch", bi.is_branch, br);
    chk("take_branch", bi.take_branch, tk);
    chk("mispredict", bi.mispredict, mp);
    chk("g_mispredict", gi.mispredict, mp);
    chk("b_pidx", bi.predict_index, base);
    chk("b_ptaken", bi.predict_taken, cnt[base] >= 2);
    chk("g_pidx", gi.predict_index, gidx);
    chk("g_ptaken", gi.predict_taken, cnt[gidx] >= 2);
    chk("b_bcount", bi.branch_count, bc);
    chk("b_mcount", bi.mispredict_count, mc);
    chk("g_bcount", gi.branch_count, bc);
    chk("g_mcount", gi.mispredict_count, mc);
  endtask

  task automatic tick();
    bit br, tk;
    ref_res(s_op, s_rt, s_z, s_n, br, tk);
    if (s_rst) begin
      for (int i = 0; i < 64; i++) cnt[i] = 1;
      ghr = 0; bc = 0; mc = 0;
    end else if (s_v && br) begin
      if (tk) cnt[s_idx] = (cnt[s_idx] < 3) ? cnt[s_idx] + 1 : 3;
      else    cnt[s_idx] = (cnt[s_idx] > 0) ? cnt[s_idx] - 1 : 0;
      ghr = ((ghr << 1) | int'(tk)) & 15;
      bc++;
      if (tk != s_pr) mc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] pc, input bit v, input int idx,
                      input bit pr, input int op, input int rtv,
                      input bit z, input bit n, input bit r);
    drive(pc, v, idx, pr, op, rtv, z, n, r);
    #1;
    check_now();
    tick();
  endtask

  task automatic peek(input logic [31:0] pc);
    drive(pc, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_now();
  endtask

  task automatic beq(input int idx, input bit t);
    step(32'h0, 1, idx, 0, 4, 0, t, 0, 0);
  endtask

  task automatic do_reset();
    step(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) cnt[i] = 0;
    ghr = 0; bc = 0; mc = 0;
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();

    // Reset state
    for (int p = 0; p < 256; p += 4) begin
      peek(32'(p));
      chk("rst_ptaken", bi.predict_taken, 1'b0);
      chk("rst_gptaken", gi.predict_taken, 1'b0);
    end
    chk("rst_bcount", bi.branch_count, 32'd0);
    chk("rst_mcount", bi.mispredict_count, 32'd0);
    tick();

    // Resolution sweep
    for (int op = 0; op < 64; op++)
      for (int r = 0; r < 3; r++)
        for (int zn = 0; zn < 4; zn++)
          step($urandom, 1, $urandom_range(63), 1'($urandom),
               op, r, zn[1], zn[0], 0);
    drive(0, 1, 0, 0, 6, 0, 0, 1, 0);
    #1;
    chk("blez_01", bi.take_branch, 1'b1);
    drive(0, 1, 0, 0, 7, 0, 0, 0, 0);
    #1;
    chk("bgtz_00", bi.take_branch, 1'b1);
    drive(0, 1, 0, 0, 1, 2, 1, 1, 0);
    #1;
    chk("regimm_rt2", bi.is_branch, 1'b0);
    drive(0, 1, 0, 0, 8, 0, 1, 0, 0);
    #1;
    chk("op08", bi.is_branch, 1'b0);
    tick();

    // Training at index 5
    do_reset();
    peek(32'h14); chk("train0", bi.predict_taken, 1'b0); tick();
    beq(5, 1);
    peek(32'h14); chk("train1", bi.predict_taken, 1'b1); tick();
    beq(5, 1);
    peek(32'h14); chk("train2", bi.predict_taken, 1'b1); tick();
    beq(5, 0);
    peek(32'h14); chk("train3", bi.predict_taken, 1'b1); tick();
    beq(5, 0);
    peek(32'h14); chk("train4", bi.predict_taken, 1'b0); tick();

    // Saturation at index 3
    for (int i = 0; i < 5; i++) beq(3, 0);
    peek(32'hC); chk("sat_lo", bi.predict_taken, 1'b0); tick();
    beq(3, 1);
    peek(32'hC); chk("sat_lo1", bi.predict_taken, 1'b0); tick();
    for (int i = 0; i < 4; i++) beq(3, 1);
    peek(32'hC); chk("sat_hi", bi.predict_taken, 1'b1); tick();
    beq(3, 0);
    peek(32'hC); chk("sat_hi1", bi.predict_taken, 1'b1); tick();
    beq(3, 0);
    peek(32'hC); chk("sat_hi2", bi.predict_taken, 1'b0); tick();

    // Statistics
    do_reset();
    for (int i = 0; i < 10; i++)
      step(0, 1, $urandom_range(63), !(i == 2 || i == 5 || i == 8),
           4, 0, 1, 0, 0);
    drive(0, 1, 9, 1, 0, 0, 1, 0, 0);
    #1;
    chk("add_mispredict", bi.mispredict, 1'b0);
    check_now();
    tick();
    peek(0);
    chk("stat_bcount", bi.branch_count, 32'd10);
    chk("stat_mcount", bi.mispredict_count, 32'd3);
    tick();

    // Gshare history
    do_reset();
    beq(0, 1); beq(0, 1); beq(0, 0); beq(0, 1);
    peek(32'h40);
    chk("gshare_idx", gi.predict_index, 32'h1D);
    chk("bimodal_idx", bi.predict_index, 32'h10);
    tick();

    // Reset mid-run
    do_reset();
    beq(7, 1); beq(7, 1);
    peek(32'h1C); chk("pre_rst", bi.predict_taken, 1'b1); tick();
    step(0, 1, 7, 0, 4, 0, 1, 0, 1);
    peek(32'h1C);
    chk("mid_rst_pt", bi.predict_taken, 1'b0);
    chk("mid_rst_bc", bi.branch_count, 32'd0);
    chk("mid_rst_mc", bi.mispredict_count, 32'd0);
    chk("mid_rst_ghr", gi.predict_index, 32'h7);
    tick();
    beq(7, 1);
    peek(32'h1C); chk("post_rst", bi.predict_taken, 1'b1); tick();

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      int ops [8] = '{0, 1, 4, 5, 6, 7, 8, 1};
      int op;
      op = ($urandom_range(9) == 0) ? $urandom_range(63)
                                    : ops[$urandom_range(7)];
      step($urandom, 1'($urandom_range(3) != 0), $urandom_range(63),
           1'($urandom), op, $urandom_range(3),
           1'($urandom), 1'($urandom), $urandom_range(60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
